interp_mac_sched: RTL and testbench

// - Time-multiplexed polyphase interpolation controller.
// - Shares ONE instance of the signed fractional multiplier `mult` across all NUM_TAPS coefficients.
// - Per input sample it produces INTERP output samples (polyphase p = 0..INTERP-1).
// - Upstream: the sample source. Downstream: the output/DAC stage.

---
 rtl/interp_mac_sched_pkg.sv | 10 +
 rtl/interp_coeff_bank.sv | 20 ++
 rtl/mult.sv | 14 +
 rtl/interp_mac_sched.sv | 100 ++++++++++
 tb/tb_interp_mac_sched.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/interp_mac_sched_pkg.sv
// interp_filt_pkg: FSM state encoding and width helpers for the interpolation MAC scheduler.
package interp_filt_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} interp_state_t;
  function automatic int acc_width(int dw, int tpp);
    return dw + $clog2(tpp);
  endfunction
  function automatic int idx_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/interp_coeff_bank.sv
// interp_coeff_bank: coefficient register file, one write port, one combinational read port.
module interp_coeff_bank #(
  parameter int N  = 8,
  parameter int W  = 6,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mult.sv
// mult: signed fractional multiplier, (a*b) >>> (BW-1) truncated to OW bits.
module mult #(
  parameter int AW = 6,
  parameter int BW = 6,
  parameter int OW = 6
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [OW-1:0] p
);
  logic signed [AW+BW-1:0] full;
  assign full = a * b;
  assign p = OW'(full >>> (BW - 1));
endmodule

// File: rtl/interp_mac_sched.sv
// interp_mac_sched: polyphase interpolator sharing one multiplier across all taps.
// Define INTERP_MAC_SAT_EN to saturate outputs instead of wrapping.
module interp_mac_sched import interp_filt_pkg::*; #(
  parameter int DATA_WIDTH      = 6,
  parameter int TAP_COEFF_WIDTH = 6,
  parameter int INTERP          = 2,
  parameter int TAPS_PER_PHASE  = 4,
  localparam int NUM_TAPS  = INTERP * TAPS_PER_PHASE,
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, TAPS_PER_PHASE),
  localparam int PW        = idx_width(INTERP),
  localparam int TW        = idx_width(TAPS_PER_PHASE),
  localparam int AW        = idx_width(NUM_TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [PW-1:0]              out_phase,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [TAP_COEFF_WIDTH-1:0] cfg_data,
  output logic                       cfg_err,
  output logic                       busy
);
  interp_state_t state;
  logic signed [DATA_WIDTH-1:0] x [TAPS_PER_PHASE];
  logic signed [ACC_WIDTH-1:0] acc, sum;
  logic [TW-1:0] tap;
  logic [PW-1:0] phase;
  logic [TAP_COEFF_WIDTH-1:0] coeff;
  logic [AW-1:0] raddr;
  logic signed [DATA_WIDTH-1:0] prod, conv;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign raddr = AW'(tap) * AW'(INTERP) + AW'(phase);
  assign sum = acc + ACC_WIDTH'(prod);
`ifdef INTERP_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = -SMAX - 1;
  assign conv = sum > SMAX ? SMAX[DATA_WIDTH-1:0] : sum < SMIN ? SMIN[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
`else
  assign conv = sum[DATA_WIDTH-1:0];
`endif
  interp_coeff_bank #(.N(NUM_TAPS), .W(TAP_COEFF_WIDTH), .AW(AW)) u_bank (
    .clk(clk), .rst_n(rst_n), .we(cfg_we && state == IDLE), .waddr(cfg_addr),
    .wdata(cfg_data), .raddr(raddr), .rdata(coeff)
  );
  mult #(.AW(DATA_WIDTH), .BW(TAP_COEFF_WIDTH), .OW(DATA_WIDTH)) u_mult (
    .a(x[tap]), .b(coeff), .p(prod)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x <= '{default: '0};
      acc <= '0;
      tap <= '0;
      phase <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_phase <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && state != IDLE;
      case (state)
        IDLE: if (in_valid) begin
          for (int k = TAPS_PER_PHASE - 1; k > 0; k--) x[k] <= x[k-1];
          x[0] <= in_data;
          acc <= '0;
          tap <= '0;
          phase <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= sum;
          tap <= tap + 1'b1;
          if (tap == TW'(TAPS_PER_PHASE - 1)) begin
            out_data <= conv;
            out_phase <= phase;
            out_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (phase == PW'(INTERP - 1)) state <= IDLE;
          else begin
            phase <= phase + 1'b1;
            acc <= '0;
            tap <= '0;
            state <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_interp_mac_sched.sv
// tb_interp_mac_sched: scoreboard bench for interp_mac_sched at default parameters.
module tb_interp_mac_sched;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, cfg_we = 0, cfg_err, busy;
  logic signed [5:0] in_data = 0, out_data;
  logic out_phase;
  logic [2:0] cfg_addr = 0;
  logic [5:0] cfg_data = 0;
  int total = 0, bad = 0;
  logic signed [5:0] exp_d [$];
  logic exp_p [$];
  logic signed [5:0] hm [8];
  logic signed [5:0] xm [4];

  always #5 clk = ~clk;

  interp_mac_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_phase(out_phase),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err), .busy(busy)
  );

  function automatic logic signed [5:0] model(int p);
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      int f;
      logic signed [5:0] t;
      f = int'(xm[k]) * int'(hm[k*2+p]);
      t = 6'(f >>> 5);
      s += int'(t);
    end
`ifdef INTERP_MAC_SAT_EN
    if (s > 31) s = 31;
    if (s < -32) s = -32;
`endif
    return 6'(s);
  endfunction

  task automatic push_sample(input logic signed [5:0] v);
    for (int k = 3; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = v;
    exp_d.push_back(model(0)); exp_p.push_back(1'b0);
    exp_d.push_back(model(1)); exp_p.push_back(1'b1);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) hm[k] = 0;
    for (int k = 0; k < 4; k++) xm[k] = 0;
    exp_d.delete(); exp_p.delete();
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_d.size() == 0) begin
        bad++;
        $display("FAIL scoreboard unexpected output data=%0d phase=%0d", out_data, out_phase);
      end else begin
        logic signed [5:0] d;
        logic p;
        d = exp_d.pop_front();
        p = exp_p.pop_front();
        if (out_data !== d || out_phase !== p) begin
          bad++;
          $display("FAIL scoreboard got data=%0d phase=%0d want data=%0d phase=%0d", out_data, out_phase, d, p);
        end
      end
    end

  task automatic wr(input int a, input int d);
    cfg_we = 1; cfg_addr = 3'(a); cfg_data = 6'(d);
    @(posedge clk); #1;
    cfg_we = 0;
    hm[a] = 6'(d);
  endtask

  task automatic send(input logic signed [5:0] v);
    int n = 0;
    in_data = v; in_valid = 1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    total++;
    if (n == 200) begin bad++; $display("FAIL send_timeout in_ready=%0b want 1", in_ready); end
    push_sample(v);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || out_valid || exp_d.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    total++;
    if (n == 200) begin bad++; $display("FAIL idle_timeout busy=%0b pending=%0d want 0", busy, exp_d.size()); end
  endtask

  task automatic test_reset();
    total += 6;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    if (out_data !== 6'sd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    if (out_phase !== 1'b0) begin bad++; $display("FAIL reset_out_phase got=%0b want=0", out_phase); end
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%0b want=0", cfg_err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
  endtask

  task automatic test_impulse();
    int n = 0;
    wr(0, 16);
    send(20);
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (n !== 4) begin bad++; $display("FAIL latency got=%0d want=4", n); end
    wait_idle();
    wr(2, 8);
    send(0);
    wait_idle();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 8; k += 2) wr(k, 31);
    for (int k = 0; k < 4; k++) send(31);
    total++;
`ifdef INTERP_MAC_SAT_EN
    if (exp_d[exp_d.size()-2] !== 6'sd31) begin bad++; $display("FAIL sat_model got=%0d want=31", exp_d[exp_d.size()-2]); end
`else
    if (exp_d[exp_d.size()-2] !== -6'sd8) begin bad++; $display("FAIL wrap_model got=%0d want=-8", exp_d[exp_d.size()-2]); end
`endif
    wait_idle();
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic signed [5:0] d0;
    out_ready = 0;
    send(5);
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    d0 = out_data;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_phase !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure valid=%0b data=%0d phase=%0b in_ready=%0b want 1/%0d/0/0", out_valid, out_data, out_phase, in_ready, d0);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    wait_idle();
  endtask

  task automatic test_cfg_busy();
    int cnt = 0;
    send(0);
    cfg_we = 1; cfg_addr = 0; cfg_data = 6'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cfg_we = 0;
      if (cfg_err) cnt++;
    end
    total++;
    if (cnt !== 1) begin bad++; $display("FAIL cfg_err_pulse got=%0d cycles want=1", cnt); end
    wait_idle();
    send(10);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    send(7);
    @(posedge clk); #1;
    rst_n = 0;
    model_reset();
    #1;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%0b want=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%0b want=1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    send(20);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int cyc = 0, last = -1, acc = 0;
    wr(0, 16);
    wr(1, 8);
    in_valid = 1;
    in_data = 6'($urandom);
    while (acc < 4 && cyc < 300) begin
      logic took;
      took = in_ready;
      if (took) begin
        if (last >= 0) begin
          total++;
          if (cyc - last !== 11) begin bad++; $display("FAIL b2b_interval got=%0d want=11", cyc - last); end
        end
        last = cyc;
        push_sample(in_data);
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        in_data = 6'($urandom);
        if (acc == 4) in_valid = 0;
      end
    end
    in_valid = 0;
    total++;
    if (acc !== 4) begin bad++; $display("FAIL b2b_accepts got=%0d want=4", acc); end
    wait_idle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_cfg_busy();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_d.size() !== 0) begin bad++; $display("FAIL leftover_expected got=%0d want=0", exp_d.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
